bcd_count_n: RTL and testbench
==============================

# bcd_count_n

Parametrised multi-digit BCD counter and the successor to the single-decade counter. It chains DIGITS decade stages internally with ripple-free carry and counts up or down under enable. It supports synchronous clear and parallel load, and gives a registered wrap pulse for cascading into further counters or display/timing logic. It sits between the lab clock-enable generators and the seven-segment/display datapath.

## Interface
- DIGITS, default 2: number of BCD decades; legal range 1–8.
- W, default 4*DIGITS: count bus width; derived, do not override.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- en  input  1  count enable; one step per clk while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clr  input  1  synchronous clear to zero.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  W  load value; nibble k = decade k, nibble 0 = least significant.
- count  output  W  current value, packed BCD, nibble 0 least significant.
- co  output  1  registered wrap pulse, one cycle wide.
- lerr  output  1  registered pulse: the last load contained an invalid nibble.

## Operation
- Reset, when rst is low, acts asynchronously: count = 0, co = 0, lerr = 0. Release is synchronised externally; the block samples rst only as an async clear.
- Per-edge priority is clr > load > en. When none of these is active, count holds.
- clr: count <= 0; co <= 0; lerr <= 0.
- load: each nibble is loaded as-is when ≤ 9. A nibble of 10–15 is forced to 9 and lerr <= 1 for one cycle. A load never asserts co.
- en with up = 1:
  - Decade 0 increments.
  - Decade k increments only when all lower decades equal 9, and each such decade goes 9 → 0.
  - When all decades equal 9 the count becomes all zeros and co <= 1.
- en with up = 0:
  - Decade 0 decrements.
  - Decade k decrements only when all lower decades equal 0, and each such decade goes 0 → 9.
  - When all decades equal 0 the count becomes all nines and co <= 1.
- co and lerr are 0 on every edge where their set condition is not met, so both are strictly one-cycle pulses.
- Every nibble of count is always in 0–9. No binary value of 10–15 is ever visible.
- Direction may change on any cycle; the step uses the up value sampled at that edge.
- DIGITS = 1 must behave as a plain mod-10 up/down counter, with co pulsing after 9 → 0 (up) or 0 → 9 (down).

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- count updates 1 clk after the qualifying edge. co and lerr assert in the same cycle count shows the wrapped or loaded value, and deassert on the next edge.
- Cascading: connect co of stage A to en of stage B with the same direction. Stage B then steps one cycle after A wraps.
- A reset asserted mid-count clears all outputs immediately, without waiting for clk. The first count step after rst rises happens on the first edge with en = 1.
- Throughput is one step per cycle with en held high continuously.

## Test plan
- Reset then up-count: rst = 0 → count = 0x00, co = 0. Release, en = 1, up = 1, 12 clocks → count = 0x12, co never high.
- Up wrap, DIGITS = 2: load 0x98, en = 1, up = 1 → 0x99, then 0x00 with co = 1 for exactly one cycle, then 0x01 with co = 0.
- Down wrap: load 0x01, up = 0 → 0x00, then 0x99 with co = 1 for one cycle. Separately, from 0x10 one down step → 0x09.
- Priority and invalid load: with en = 1, assert clr and load together → count = 0x00. Then load 0xA3 alone → count = 0x93, lerr = 1 for one cycle, co = 0.
- Async reset mid-operation: count at 0x57, drop rst between edges → count = 0x00 before the next rising edge. Hold en = 0 after release → count stays 0x00.
- DIGITS = 1 and DIGITS = 4:
  - DIGITS = 1, up = 1, run 20 cycles → co pulses at cycles 10 and 20.
  - DIGITS = 4, load 0x9999, one up step → 0x0000 with co = 1.

Source files
------------

// File: rtl/bcd_count_n.sv
// bcd_count_n: parametrised multi-decade BCD up/down counter.
//
// Chains DIGITS decade stages that all update on the same clock edge, with
// synchronous clear, saturating parallel load, and one-cycle wrap (co) and
// load-error (lerr) pulses for cascading into further counters or display
// logic. All outputs come straight from flops.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset (0 = reset)
//   en       in   count enable, one step per clock while high
//   up       in   direction: 1 = increment, 0 = decrement
//   clr      in   synchronous clear (highest priority)
//   load     in   synchronous parallel load of load_val
//   load_val in   [W] packed BCD load value, nibble 0 least significant
//   count    out  [W] current value, packed BCD, nibble 0 least significant
//   co       out  registered wrap pulse, one cycle wide
//   lerr     out  registered pulse: last load held a nibble of 10-15
module bcd_count_n #(
  parameter int DIGITS = 2,
  parameter int W      = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         co,
  output logic         lerr
);

  logic [W-1:0]      count_q, count_d;
  logic              co_q, co_d;
  logic              lerr_q, lerr_d;
  logic [DIGITS-1:0] is_nine;
  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] step;
  logic              wrap;

  // Clamp an out-of-range load nibble to 9 so count never shows 10-15.
  function automatic logic [3:0] sat_nibble(input logic [3:0] n);
    if (n > 4'd9) begin
      return 4'd9;
    end else begin
      return n;
    end
  endfunction

  // One decade step in the requested direction, wrapping 9<->0.
  function automatic logic [3:0] next_digit(input logic [3:0] d, input logic dir_up);
    logic [3:0] r;
    if (dir_up) begin
      r = (d == 4'd9) ? 4'd0 : d + 4'd1;
    end else begin
      r = (d == 4'd0) ? 4'd9 : d - 4'd1;
    end
    return r;
  endfunction

  // Per-decade terminal flags and the "all lower decades terminal" step enables.
  always_comb begin : step_logic
    logic carry;
    carry   = 1'b1;
    is_nine = {DIGITS{1'b0}};
    is_zero = {DIGITS{1'b0}};
    step    = {DIGITS{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      is_nine[k] = (count_q[4*k +: 4] == 4'd9);
      is_zero[k] = (count_q[4*k +: 4] == 4'd0);
      step[k]    = carry;
      // A decade passes the step upward only when it is about to wrap.
      carry      = carry & (up ? is_nine[k] : is_zero[k]);
    end
    wrap = carry;
  end

  // Next-state selection with priority clr > load > en > hold.
  always_comb begin
    count_d = count_q;
    co_d    = 1'b0;
    lerr_d  = 1'b0;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (load) begin
      for (int k = 0; k < DIGITS; k++) begin
        count_d[4*k +: 4] = sat_nibble(load_val[4*k +: 4]);
        lerr_d            = lerr_d | (load_val[4*k +: 4] > 4'd9);
      end
    end else if (en) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (step[k]) begin
          count_d[4*k +: 4] = next_digit(count_q[4*k +: 4], up);
        end else begin
          count_d[4*k +: 4] = count_q[4*k +: 4];
        end
      end
      co_d = wrap;
    end else begin
      count_d = count_q;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= {W{1'b0}};
      co_q    <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      co_q    <= co_d;
      lerr_q  <= lerr_d;
    end
  end

  assign count = count_q;
  assign co    = co_q;
  assign lerr  = lerr_q;

endmodule

// File: tb/tb_bcd_count_n.sv
// Testbench for bcd_count_n: three instances (DIGITS = 1, 2, 4) share one
// stimulus stream. A decimal-integer reference model predicts each cycle's
// outputs; predictions are queued and a monitor compares them after each edge.
module tb_bcd_count_n;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        clr;
  logic        load;
  logic [31:0] load_val;

  logic [3:0]  count1;
  logic [7:0]  count2;
  logic [15:0] count4;
  logic        co1, co2, co4;
  logic        lerr1, lerr2, lerr4;

  int n_cmp;
  int n_err;

  typedef struct packed {
    logic [15:0] c4;
    logic [7:0]  c2;
    logic [3:0]  c1;
    logic [2:0]  co;
    logic [2:0]  le;
  } exp_t;

  exp_t exp_q[$];

  // Model state: decimal value per instance (index 0: 1 digit, 1: 2, 2: 4).
  int mv[3];
  int dg[3] = '{1, 2, 4};

  bcd_count_n #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .count(count1), .co(co1), .lerr(lerr1));

  bcd_count_n #(.DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val[7:0]), .count(count2), .co(co2), .lerr(lerr2));

  bcd_count_n #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val[15:0]), .count(count4), .co(co4), .lerr(lerr4));

  // Clock: rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int modulus(input int d);
    int m = 1;
    for (int k = 0; k < d; k++) m = m * 10;
    return m;
  endfunction

  function automatic logic [15:0] to_bcd(input int v, input int d);
    logic [15:0] r = 16'h0;
    int t = v;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One clock of stimulus: drive inputs, predict next outputs, wait for next negedge.
  task automatic cyc(input logic e, input logic u, input logic c, input logic l,
                     input logic [31:0] lv);
    exp_t x;
    logic [15:0] ce[3];
    logic [2:0] coe, lee;
    en = e; up = u; clr = c; load = l; load_val = lv;
    coe = 3'b000;
    lee = 3'b000;
    for (int i = 0; i < 3; i++) begin
      int m = modulus(dg[i]);
      if (!rst) begin
        mv[i] = 0;
      end else if (c) begin
        mv[i] = 0;
      end else if (l) begin
        int v = 0;
        for (int k = dg[i] - 1; k >= 0; k--) begin
          int nib = int'(lv[4*k +: 4]);
          if (nib > 9) begin
            nib = 9;
            lee[i] = 1'b1;
          end
          v = v * 10 + nib;
        end
        mv[i] = v;
      end else if (e) begin
        if (u) begin
          coe[i] = (mv[i] == m - 1);
          mv[i] = (mv[i] + 1) % m;
        end else begin
          coe[i] = (mv[i] == 0);
          mv[i] = (mv[i] + m - 1) % m;
        end
      end
      ce[i] = to_bcd(mv[i], dg[i]);
    end
    x.c1 = ce[0][3:0];
    x.c2 = ce[1][7:0];
    x.c4 = ce[2];
    x.co = coe;
    x.le = lee;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: after every rising edge, check the oldest pending prediction.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("count_d1", {28'h0, count1}, {28'h0, x.c1});
        chk("count_d2", {24'h0, count2}, {24'h0, x.c2});
        chk("count_d4", {16'h0, count4}, {16'h0, x.c4});
        chk("co_d1",   {31'h0, co1},   {31'h0, x.co[0]});
        chk("co_d2",   {31'h0, co2},   {31'h0, x.co[1]});
        chk("co_d4",   {31'h0, co4},   {31'h0, x.co[2]});
        chk("lerr_d1", {31'h0, lerr1}, {31'h0, x.le[0]});
        chk("lerr_d2", {31'h0, lerr2}, {31'h0, x.le[1]});
        chk("lerr_d4", {31'h0, lerr4}, {31'h0, x.le[2]});
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_c1"}, {28'h0, count1}, 32'h0);
    chk({nm, "_c2"}, {24'h0, count2}, 32'h0);
    chk({nm, "_c4"}, {16'h0, count4}, 32'h0);
    chk({nm, "_co"}, {29'h0, co1, co2, co4}, 32'h0);
    chk({nm, "_le"}, {29'h0, lerr1, lerr2, lerr4}, 32'h0);
  endtask

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    n_cmp = 0;
    n_err = 0;
    mv = '{0, 0, 0};
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 32'h0;
    #1 rst = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Up-count 12 steps from zero.
    repeat (12) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("upcount12", {24'h0, count2}, 32'h12);

    // Up wrap through 99 -> 00.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_9998);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

    // Down wrap through 00 -> 99, then a borrow across a decade.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0001);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("borrow_10_09", {24'h0, count2}, 32'h09);

    // clr beats load and en; invalid nibble saturates.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0099);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_00A3);
    chk("load_sat", {24'h0, count2}, 32'h93);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset between edges.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0057);
    #2 rst = 1'b0;
    mv = '{0, 0, 0};
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Twenty up steps from zero: single-decade co every tenth step.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (20) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

    // Four-decade full wrap.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_9999);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap4", {16'h0, count4}, 32'h0);
    chk("wrap4_co", {31'h0, co4}, 32'h1);

    // Randomized traffic, with loads biased towards near-terminal values.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] lv;
      int sel;
      logic e, u, c, l;
      sel = int'($urandom_range(0, 99));
      c = (sel < 3);
      l = (sel >= 3 && sel < 13);
      e = ($urandom_range(0, 9) < 8);
      u = ($urandom_range(0, 3) != 0) ? ((n / 50) % 2 == 0) : 1'($urandom);
      lv = $urandom;
      if (sel < 8) lv = 32'h9999_9998;
      cyc(e, u, c, l, lv);
    end

    // Drain outstanding predictions with a bounded wait.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
